mem_bus_arbiter: RTL and testbench

Parametrised N-master / S-slave memory crossbar. It generalises the fixed CPU+DMA memory map into a table-driven decoder with per-slave arbitration. Each slave has an independent arbiter (fixed-priority or round-robin) with bus-lock support. The block also provides valid/ready request handshakes and pipelined read-data return routing that matches the slave read latency. It sits between the CPU, OAM-DMA, PPU and other masters and the ROM/MRAM/HRAM/MMIO slaves.

---
 rtl/mem_bus_arbiter_pkg.sv | 19 +
 rtl/mem_bus_arbiter_if.sv | 33 +++
 rtl/mem_bus_arbiter_slave_arb.sv | 109 ++++++++++
 rtl/mem_bus_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants and types for the mem_bus_arbiter crossbar (package mem_bus_pkg).
package mem_bus_pkg;

  localparam int MAX_MASTERS = 8;
  localparam int MAX_SLAVES  = 16;

  localparam logic [7:0] UNMAPPED_DATA = 8'hFF;

  typedef struct packed {
    logic       valid;
    logic [2:0] master;
  } rd_tag_t;

  typedef enum logic [0:0] {
    LK_IDLE   = 1'b0,
    LK_LOCKED = 1'b1
  } lock_state_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Master-side request/return bus and slave-side access bus of the crossbar.
// The crossbar uses the slave modport; the masters and memories use the master modport.
interface mem_bus_arbiter_if #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 5
);

  logic [NUM_MASTERS-1:0]    m_valid;
  logic [NUM_MASTERS-1:0]    m_ready;
  logic [NUM_MASTERS-1:0]    m_lock;
  logic [NUM_MASTERS*16-1:0] m_addr;
  logic [NUM_MASTERS-1:0]    m_we;
  logic [NUM_MASTERS*8-1:0]  m_wdata;
  logic [NUM_MASTERS-1:0]    m_rvalid;
  logic [NUM_MASTERS*8-1:0]  m_rdata;

  logic [NUM_SLAVES-1:0]     s_en;
  logic [NUM_SLAVES*16-1:0]  s_addr;
  logic [NUM_SLAVES-1:0]     s_we;
  logic [NUM_SLAVES*8-1:0]   s_wdata;
  logic [NUM_SLAVES*8-1:0]   s_rdata;

  modport slave (
    input  m_valid, m_lock, m_addr, m_we, m_wdata, s_rdata,
    output m_ready, m_rvalid, m_rdata, s_en, s_addr, s_we, s_wdata
  );

  modport master (
    output m_valid, m_lock, m_addr, m_we, m_wdata, s_rdata,
    input  m_ready, m_rvalid, m_rdata, s_en, s_addr, s_we, s_wdata
  );

endinterface

// File: rtl/mem_bus_arbiter_slave_arb.sv
// Per-slave arbiter (mem_bus_slave_arb): fixed-priority or round-robin grant, bus-lock
// state machine and the read-tag pipeline that routes return data back to the grantee.
module mem_bus_slave_arb
  import mem_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int READ_LAT    = 1,
  parameter int ARB_RR      = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [NUM_MASTERS-1:0] lock,
  input  logic [NUM_MASTERS-1:0] we,
  output logic [NUM_MASTERS-1:0] grant,
  output rd_tag_t                tag_out
);

  localparam int IDX_W = $clog2(MAX_MASTERS);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  lock_state_t      lk_state;

  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_lock;
  logic             gnt_we;
  logic             hi_valid, lo_valid;
  logic [IDX_W-1:0] hi_idx, lo_idx;

  rd_tag_t tag_sr [READ_LAT];

  // Round-robin: the first requester at or above rr_ptr wins, else wrap to the lowest one.
  always_comb begin
    hi_valid = 1'b0;
    hi_idx   = '0;
    lo_valid = 1'b0;
    lo_idx   = '0;
    for (int m = NUM_MASTERS - 1; m >= 0; m--) begin
      if (req[m]) begin
        lo_valid = 1'b1;
        lo_idx   = IDX_W'(m);
        if (IDX_W'(m) >= rr_ptr) begin
          hi_valid = 1'b1;
          hi_idx   = IDX_W'(m);
        end
      end
    end

    gnt_valid = 1'b0;
    gnt_idx   = '0;
    if (!rst) begin
      if (lk_state == LK_LOCKED) begin
        for (int m = 0; m < NUM_MASTERS; m++) begin
          if (owner == IDX_W'(m) && req[m]) begin
            gnt_valid = 1'b1;
            gnt_idx   = IDX_W'(m);
          end
        end
      end else if (ARB_RR != 0 && hi_valid) begin
        gnt_valid = 1'b1;
        gnt_idx   = hi_idx;
      end else begin
        gnt_valid = lo_valid;
        gnt_idx   = lo_idx;
      end
    end
  end

  always_comb begin
    grant    = '0;
    gnt_lock = 1'b0;
    gnt_we   = 1'b0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      if (gnt_valid && gnt_idx == IDX_W'(m)) begin
        grant[m] = 1'b1;
        gnt_lock = lock[m];
        gnt_we   = we[m];
      end
    end
  end

  // While locked only the owner is ever granted, so any grant with lock=0 releases it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      owner    <= '0;
      lk_state <= LK_IDLE;
      for (int i = 0; i < READ_LAT; i++) tag_sr[i] <= '0;
    end else begin
      if (gnt_valid) begin
        rr_ptr <= (int'(gnt_idx) == NUM_MASTERS - 1) ? '0 : gnt_idx + 1'b1;
        if (lk_state == LK_IDLE && gnt_lock) begin
          lk_state <= LK_LOCKED;
          owner    <= gnt_idx;
        end else if (lk_state == LK_LOCKED && !gnt_lock) begin
          lk_state <= LK_IDLE;
        end
      end
      tag_sr[0].valid  <= gnt_valid && !gnt_we;
      tag_sr[0].master <= gnt_idx;
      for (int i = 1; i < READ_LAT; i++) tag_sr[i] <= tag_sr[i-1];
    end
  end

  assign tag_out = tag_sr[READ_LAT-1];

endmodule

// File: rtl/mem_bus_arbiter.sv
// N-master / S-slave memory crossbar: table-driven address decode, per-slave arbitration
// and latency-matched read return. Define MEM_BUS_ARB_STATS_EN to add per-master stall_cnt.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 5,
  parameter int NUM_REGIONS = 8,
  parameter int READ_LAT    = 1,
  parameter int ARB_RR      = 0,
  parameter logic [NUM_REGIONS*16-1:0] REGION_BASE   = '0,
  parameter logic [NUM_REGIONS*17-1:0] REGION_END    = '0,
  parameter logic [NUM_REGIONS*4-1:0]  REGION_SLAVE  = '0,
  parameter logic [NUM_REGIONS*16-1:0] REGION_OFFSET = '0
) (
  input  logic               clk,
  input  logic               rst,
  mem_bus_arbiter_if.slave   bus
`ifdef MEM_BUS_ARB_STATS_EN
  ,
  output logic [NUM_MASTERS*16-1:0] stall_cnt
`endif
);

  localparam int SIDX_W = $clog2(MAX_SLAVES);

  logic [NUM_MASTERS-1:0] hit;
  logic [SIDX_W-1:0]      tgt      [NUM_MASTERS];
  logic [15:0]            fwd_addr [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] m_gnt;

  logic [NUM_MASTERS-1:0] slv_req [NUM_SLAVES];
  logic [NUM_MASTERS-1:0] slv_gnt [NUM_SLAVES];
  rd_tag_t                slv_tag [NUM_SLAVES];

  logic [NUM_MASTERS-1:0] unm_sr [READ_LAT];

  // Scanning regions from the top down lets the lowest matching index overwrite the rest.
  always_comb begin
    for (int m = 0; m < NUM_MASTERS; m++) begin
      hit[m]      = 1'b0;
      tgt[m]      = '0;
      fwd_addr[m] = '0;
      for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
        if (bus.m_addr[m*16 +: 16] >= REGION_BASE[r*16 +: 16] &&
            {1'b0, bus.m_addr[m*16 +: 16]} < REGION_END[r*17 +: 17]) begin
          hit[m]      = int'(REGION_SLAVE[r*SIDX_W +: SIDX_W]) < NUM_SLAVES;
          tgt[m]      = REGION_SLAVE[r*SIDX_W +: SIDX_W];
          fwd_addr[m] = bus.m_addr[m*16 +: 16] + REGION_OFFSET[r*16 +: 16];
        end
      end
    end
  end

  always_comb begin
    for (int s = 0; s < NUM_SLAVES; s++) begin
      for (int m = 0; m < NUM_MASTERS; m++) begin
        slv_req[s][m] = bus.m_valid[m] && hit[m] && tgt[m] == SIDX_W'(s);
      end
    end
  end

  for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_slave
    mem_bus_slave_arb #(
      .NUM_MASTERS (NUM_MASTERS),
      .READ_LAT    (READ_LAT),
      .ARB_RR      (ARB_RR)
    ) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (slv_req[s]),
      .lock    (bus.m_lock),
      .we      (bus.m_we),
      .grant   (slv_gnt[s]),
      .tag_out (slv_tag[s])
    );
  end

  always_comb begin
    bus.s_en    = '0;
    bus.s_addr  = '0;
    bus.s_we    = '0;
    bus.s_wdata = '0;
    m_gnt       = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      for (int m = 0; m < NUM_MASTERS; m++) begin
        if (slv_gnt[s][m]) begin
          m_gnt[m]                 = 1'b1;
          bus.s_en[s]              = 1'b1;
          bus.s_addr[s*16 +: 16]   = fwd_addr[m];
          bus.s_we[s]              = bus.m_we[m];
          bus.s_wdata[s*8 +: 8]    = bus.m_wdata[m*8 +: 8];
        end
      end
    end
  end

  // Unmapped accesses complete at once; writes vanish and reads return UNMAPPED_DATA.
  always_comb begin
    for (int m = 0; m < NUM_MASTERS; m++) begin
      bus.m_ready[m] = !rst && bus.m_valid[m] && (!hit[m] || m_gnt[m]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < READ_LAT; i++) unm_sr[i] <= '0;
    end else begin
      unm_sr[0] <= bus.m_valid & ~hit & ~bus.m_we;
      for (int i = 1; i < READ_LAT; i++) unm_sr[i] <= unm_sr[i-1];
    end
  end

  always_comb begin
    bus.m_rvalid = unm_sr[READ_LAT-1];
    bus.m_rdata  = {NUM_MASTERS{UNMAPPED_DATA}};
    for (int s = 0; s < NUM_SLAVES; s++) begin
      for (int m = 0; m < NUM_MASTERS; m++) begin
        if (slv_tag[s].valid && slv_tag[s].master == 3'(m)) begin
          bus.m_rvalid[m]         = 1'b1;
          bus.m_rdata[m*8 +: 8]   = bus.s_rdata[s*8 +: 8];
        end
      end
    end
  end

`ifdef MEM_BUS_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else begin
      for (int m = 0; m < NUM_MASTERS; m++) begin
        if (bus.m_valid[m] && !bus.m_ready[m] && stall_cnt[m*16 +: 16] != 16'hFFFF) begin
          stall_cnt[m*16 +: 16] <= stall_cnt[m*16 +: 16] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a fixed-priority and a round-robin crossbar with
// READ_LAT=1 plus a fixed-priority crossbar with READ_LAT=3, all driven by the same masters.
module tb_mem_bus_arbiter;

  localparam int NM = 2;
  localparam int NS = 2;
  localparam int NR = 4;

  // 0x0000-0x7FFF -> s0; 0x8000-0x9FFF -> s1 at 0x0000; 0x7000-0x8FFF shadowed; 0xFF00-0xFFFF -> s1 at +0x100
  localparam logic [NR*16-1:0] R_BASE = {16'hFF00, 16'h7000, 16'h8000, 16'h0000};
  localparam logic [NR*17-1:0] R_END  = {17'h10000, 17'h09000, 17'h0A000, 17'h08000};
  localparam logic [NR*4-1:0]  R_SLV  = {4'd1, 4'd1, 4'd1, 4'd0};
  localparam logic [NR*16-1:0] R_OFS  = {16'h0100, 16'h0000, 16'h8000, 16'h0000};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NM-1:0]    m_valid;
  logic [NM-1:0]    m_lock;
  logic [NM-1:0]    m_we;
  logic [NM*16-1:0] m_addr;
  logic [NM*8-1:0]  m_wdata;

  int checks   = 0;
  int failures = 0;

  mem_bus_arbiter_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS)) bus_a ();
  mem_bus_arbiter_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS)) bus_b ();
  mem_bus_arbiter_if #(.NUM_MASTERS(NM), .NUM_SLAVES(NS)) bus_c ();

  assign bus_a.m_valid = m_valid;
  assign bus_a.m_lock  = m_lock;
  assign bus_a.m_we    = m_we;
  assign bus_a.m_addr  = m_addr;
  assign bus_a.m_wdata = m_wdata;
  assign bus_b.m_valid = m_valid;
  assign bus_b.m_lock  = m_lock;
  assign bus_b.m_we    = m_we;
  assign bus_b.m_addr  = m_addr;
  assign bus_b.m_wdata = m_wdata;
  assign bus_c.m_valid = m_valid;
  assign bus_c.m_lock  = m_lock;
  assign bus_c.m_we    = m_we;
  assign bus_c.m_addr  = m_addr;
  assign bus_c.m_wdata = m_wdata;

  // Memory model: read data is the low address byte ^ 0xA0 ^ slave index, delayed by the latency.
  function automatic logic [7:0] slaveData(input logic [15:0] a, input int s);
    return a[7:0] ^ 8'hA0 ^ 8'(s);
  endfunction

  logic [7:0] pipe_a [NS];
  logic [7:0] pipe_b [NS];
  logic [7:0] pipe_c [NS][3];

  always @(posedge clk) begin
    for (int s = 0; s < NS; s++) begin
      pipe_a[s]    <= slaveData(bus_a.s_addr[s*16 +: 16], s);
      pipe_b[s]    <= slaveData(bus_b.s_addr[s*16 +: 16], s);
      pipe_c[s][0] <= slaveData(bus_c.s_addr[s*16 +: 16], s);
      pipe_c[s][1] <= pipe_c[s][0];
      pipe_c[s][2] <= pipe_c[s][1];
    end
  end

  assign bus_a.s_rdata = {pipe_a[1], pipe_a[0]};
  assign bus_b.s_rdata = {pipe_b[1], pipe_b[0]};
  assign bus_c.s_rdata = {pipe_c[1][2], pipe_c[0][2]};

`ifdef MEM_BUS_ARB_STATS_EN
  logic [NM*16-1:0] stall_a, stall_b, stall_c;
`endif

  mem_bus_arbiter #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS), .NUM_REGIONS(NR), .READ_LAT(1), .ARB_RR(0),
    .REGION_BASE(R_BASE), .REGION_END(R_END), .REGION_SLAVE(R_SLV), .REGION_OFFSET(R_OFS)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
`ifdef MEM_BUS_ARB_STATS_EN
    , .stall_cnt (stall_a)
`endif
  );

  mem_bus_arbiter #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS), .NUM_REGIONS(NR), .READ_LAT(1), .ARB_RR(1),
    .REGION_BASE(R_BASE), .REGION_END(R_END), .REGION_SLAVE(R_SLV), .REGION_OFFSET(R_OFS)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
`ifdef MEM_BUS_ARB_STATS_EN
    , .stall_cnt (stall_b)
`endif
  );

  mem_bus_arbiter #(
    .NUM_MASTERS(NM), .NUM_SLAVES(NS), .NUM_REGIONS(NR), .READ_LAT(3), .ARB_RR(0),
    .REGION_BASE(R_BASE), .REGION_END(R_END), .REGION_SLAVE(R_SLV), .REGION_OFFSET(R_OFS)
  ) dut_c (
    .clk (clk),
    .rst (rst),
    .bus (bus_c)
`ifdef MEM_BUS_ARB_STATS_EN
    , .stall_cnt (stall_c)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Inputs change on the falling edge; combinational outputs are sampled 1 ns later.
  task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] lock, input logic [1:0] we,
                               input logic [15:0] a0, input logic [15:0] a1,
                               input logic [7:0] w0, input logic [7:0] w1);
    @(negedge clk);
    m_valid = valid;
    m_lock  = lock;
    m_we    = we;
    m_addr  = {a1, a0};
    m_wdata = {w1, w0};
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 8'h00, 8'h00);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst     = 1'b1;
    m_valid = '0;
    m_lock  = '0;
    m_we    = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    m_valid = '0;
    m_lock  = '0;
    m_we    = '0;
    m_addr  = '0;
    m_wdata = '0;

    @(negedge clk);
    #1;
    checkOutput("rst_ready",  32'(bus_a.m_ready),  32'h0);
    checkOutput("rst_rvalid", 32'(bus_a.m_rvalid), 32'h0);
    checkOutput("rst_rdata",  32'(bus_a.m_rdata),  32'hFFFF);
    checkOutput("rst_s_en",   32'(bus_a.s_en),     32'h0);
    checkOutput("rst_s_addr", 32'(bus_a.s_addr),   32'h0);
    checkOutput("rst_rdata_c", 32'(bus_c.m_rdata), 32'hFFFF);
`ifdef MEM_BUS_ARB_STATS_EN
    checkOutput("rst_stall", 32'(stall_a), 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Basic decode with negative offset and one-cycle read return
    applyStimulus(2'b01, 2'b00, 2'b00, 16'h8010, 16'h0000, 8'h00, 8'h00);
    checkOutput("t1_ready",  32'(bus_a.m_ready), 32'h1);
    checkOutput("t1_s_en",   32'(bus_a.s_en),    32'h2);
    checkOutput("t1_s_addr", 32'(bus_a.s_addr),  32'h0010_0000);
    idleCycle();
    checkOutput("t1_rvalid", 32'(bus_a.m_rvalid), 32'h1);
    checkOutput("t1_rdata",  32'(bus_a.m_rdata),  32'hFFB1);

    // Region edges, 0x10000 end and offset wrap; two slaves served in one cycle
    applyStimulus(2'b11, 2'b00, 2'b00, 16'h7FFF, 16'hFFFF, 8'h00, 8'h00);
    checkOutput("edge_ready",  32'(bus_a.m_ready), 32'h3);
    checkOutput("edge_s_en",   32'(bus_a.s_en),    32'h3);
    checkOutput("edge_s_addr", 32'(bus_a.s_addr),  32'h00FF_7FFF);
    idleCycle();
    checkOutput("edge_rvalid", 32'(bus_a.m_rvalid), 32'h3);
    checkOutput("edge_rdata",  32'(bus_a.m_rdata),  32'h5E5F);

    // Overlapping regions: lower index wins
    applyStimulus(2'b01, 2'b00, 2'b00, 16'h8FFF, 16'h0000, 8'h00, 8'h00);
    checkOutput("prio_s_addr", 32'(bus_a.s_addr), 32'h0FFF_0000);

    // Write path: no read return
    applyStimulus(2'b01, 2'b00, 2'b01, 16'h0123, 16'h0000, 8'h77, 8'h00);
    checkOutput("wr_s_en",    32'(bus_a.s_en),    32'h1);
    checkOutput("wr_s_we",    32'(bus_a.s_we),    32'h1);
    checkOutput("wr_s_addr",  32'(bus_a.s_addr),  32'h0000_0123);
    checkOutput("wr_s_wdata", 32'(bus_a.s_wdata), 32'h0077);
    idleCycle();
    checkOutput("wr_rvalid", 32'(bus_a.m_rvalid), 32'h0);

    // Fixed priority collision on slave 1
    applyStimulus(2'b11, 2'b00, 2'b00, 16'h8020, 16'h8030, 8'h00, 8'h00);
    checkOutput("fix_c1_ready",  32'(bus_a.m_ready), 32'h1);
    checkOutput("fix_c1_s_addr", 32'(bus_a.s_addr),  32'h0020_0000);
    applyStimulus(2'b10, 2'b00, 2'b00, 16'h8020, 16'h8030, 8'h00, 8'h00);
    checkOutput("fix_c2_ready",  32'(bus_a.m_ready),  32'h2);
    checkOutput("fix_c2_s_addr", 32'(bus_a.s_addr),   32'h0030_0000);
    checkOutput("fix_c2_rvalid", 32'(bus_a.m_rvalid), 32'h1);
    checkOutput("fix_c2_rdata",  32'(bus_a.m_rdata),  32'hFF81);
    idleCycle();
    checkOutput("fix_c3_rvalid", 32'(bus_a.m_rvalid), 32'h2);
    checkOutput("fix_c3_rdata",  32'(bus_a.m_rdata),  32'h91FF);
`ifdef MEM_BUS_ARB_STATS_EN
    checkOutput("stall_m1", 32'(stall_a), 32'h0001_0000);
`endif

    // Round-robin alternation versus fixed-priority starvation
    pulseReset();
    applyStimulus(2'b11, 2'b00, 2'b00, 16'h8040, 16'h8050, 8'h00, 8'h00);
    checkOutput("rr_c1_ready", 32'(bus_b.m_ready), 32'h1);
    applyStimulus(2'b11, 2'b00, 2'b00, 16'h8040, 16'h8050, 8'h00, 8'h00);
    checkOutput("rr_c2_ready",  32'(bus_b.m_ready),  32'h2);
    checkOutput("rr_c2_rvalid", 32'(bus_b.m_rvalid), 32'h1);
    checkOutput("rr_c2_rdata",  32'(bus_b.m_rdata),  32'hFFE1);
    applyStimulus(2'b11, 2'b00, 2'b00, 16'h8040, 16'h8050, 8'h00, 8'h00);
    checkOutput("rr_c3_ready", 32'(bus_b.m_ready), 32'h1);
    applyStimulus(2'b11, 2'b00, 2'b00, 16'h8040, 16'h8050, 8'h00, 8'h00);
    checkOutput("rr_c4_ready",  32'(bus_b.m_ready), 32'h2);
    checkOutput("fix_c4_ready", 32'(bus_a.m_ready), 32'h1);

    // Bus lock held by master 1 across an idle cycle, then released
    pulseReset();
    applyStimulus(2'b10, 2'b10, 2'b10, 16'h0000, 16'h8001, 8'h00, 8'h55);
    checkOutput("lk_c1_ready", 32'(bus_a.m_ready), 32'h2);
    checkOutput("lk_c1_s_we",  32'(bus_a.s_we),    32'h2);
    checkOutput("lk_c1_wdata", 32'(bus_a.s_wdata), 32'h5500);
    applyStimulus(2'b01, 2'b00, 2'b00, 16'h8002, 16'h8001, 8'h00, 8'h00);
    checkOutput("lk_c2_ready",  32'(bus_a.m_ready),  32'h0);
    checkOutput("lk_c2_s_en",   32'(bus_a.s_en),     32'h0);
    checkOutput("lk_c2_rvalid", 32'(bus_a.m_rvalid), 32'h0);
    applyStimulus(2'b01, 2'b00, 2'b00, 16'h8002, 16'h8001, 8'h00, 8'h00);
    checkOutput("lk_c3_ready", 32'(bus_a.m_ready), 32'h0);
    applyStimulus(2'b11, 2'b00, 2'b10, 16'h8002, 16'h8003, 8'h00, 8'h66);
    checkOutput("lk_c4_ready", 32'(bus_a.m_ready), 32'h2);
    applyStimulus(2'b01, 2'b00, 2'b00, 16'h8002, 16'h8003, 8'h00, 8'h00);
    checkOutput("lk_c5_ready",  32'(bus_a.m_ready), 32'h1);
    checkOutput("lk_c5_s_addr", 32'(bus_a.s_addr),  32'h0002_0000);

    // Unmapped read and write complete at once and never touch a slave
    pulseReset();
    applyStimulus(2'b11, 2'b00, 2'b10, 16'hFEA5, 16'hA000, 8'h00, 8'h12);
    checkOutput("unm_ready",   32'(bus_a.m_ready), 32'h3);
    checkOutput("unm_s_en",    32'(bus_a.s_en),    32'h0);
    checkOutput("unm_ready_c", 32'(bus_c.m_ready), 32'h3);
    idleCycle();
    checkOutput("unm_rvalid",    32'(bus_a.m_rvalid), 32'h1);
    checkOutput("unm_rdata",     32'(bus_a.m_rdata),  32'hFFFF);
    checkOutput("unm_c1_rvalid", 32'(bus_c.m_rvalid), 32'h0);
    idleCycle();
    checkOutput("unm_c2_rvalid", 32'(bus_c.m_rvalid), 32'h0);
    idleCycle();
    checkOutput("unm_c3_rvalid", 32'(bus_c.m_rvalid), 32'h1);

    // READ_LAT=3 back-to-back reads
    pulseReset();
    applyStimulus(2'b01, 2'b00, 2'b00, 16'h8060, 16'h0000, 8'h00, 8'h00);
    applyStimulus(2'b01, 2'b00, 2'b00, 16'h8061, 16'h0000, 8'h00, 8'h00);
    applyStimulus(2'b01, 2'b00, 2'b00, 16'h8062, 16'h0000, 8'h00, 8'h00);
    checkOutput("lat3_early_rvalid", 32'(bus_c.m_rvalid), 32'h0);
    idleCycle();
    checkOutput("lat3_r0_rvalid", 32'(bus_c.m_rvalid), 32'h1);
    checkOutput("lat3_r0_rdata",  32'(bus_c.m_rdata),  32'hFFC1);
    idleCycle();
    checkOutput("lat3_r1_rdata",  32'(bus_c.m_rdata),  32'hFFC0);
    idleCycle();
    checkOutput("lat3_r2_rdata",  32'(bus_c.m_rdata),  32'hFFC3);
    idleCycle();
    checkOutput("lat3_done_rvalid", 32'(bus_c.m_rvalid), 32'h0);

    // Reset while two reads are in flight discards them
    applyStimulus(2'b01, 2'b00, 2'b00, 16'h8070, 16'h0000, 8'h00, 8'h00);
    applyStimulus(2'b01, 2'b00, 2'b00, 16'h8071, 16'h0000, 8'h00, 8'h00);
    @(negedge clk);
    rst     = 1'b1;
    m_valid = '0;
    #1;
    checkOutput("mid_rst_rvalid", 32'(bus_c.m_rvalid), 32'h0);
    checkOutput("mid_rst_rdata",  32'(bus_c.m_rdata),  32'hFFFF);
    checkOutput("mid_rst_s_en",   32'(bus_c.s_en),     32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_rvalid0", 32'(bus_c.m_rvalid), 32'h0);
    for (int i = 1; i <= 3; i++) begin
      idleCycle();
      checkOutput($sformatf("post_rst_rvalid%0d", i), 32'(bus_c.m_rvalid), 32'h0);
      checkOutput($sformatf("post_rst_rdata%0d", i),  32'(bus_c.m_rdata),  32'hFFFF);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
